alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_sequencer_if.sv | 36 +++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/alu_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the ALU sequencer.
//   op_e          : operation encodings presented on op_sel0/op_sel1/alu_op
//   state_e       : sequencer FSM states
//   DEF_*_CYCLES  : default EXEC-phase lengths for the multi-cycle operations
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_EXEC = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int DEF_MUL_CYCLES = 8;
  localparam int DEF_DIV_CYCLES = 8;

endpackage

// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if -- request/grant and ALU-control bundle of the sequencer.
//   req[1:0]      : per-requester level request
//   op_sel0/1     : requester 0/1 operation select
//   gnt[1:0]      : one-hot grant pulse
//   load_alu      : ALU load strobe
//   alu_op[1:0]   : operation presented to the ALU
//   alu_step      : ALU iterate enable
//   busy          : sequencer not idle
//   done/done_id  : completion pulse and requester index
//   err           : unsupported-operation flag (with done)
// Modports: master = requester/ALU side, slave = sequencer.
// ---------------------------------------------------------------------------
interface alu_sequencer_if;
  logic [1:0] req;
  logic [1:0] op_sel0;
  logic [1:0] op_sel1;
  logic [1:0] gnt;
  logic       load_alu;
  logic [1:0] alu_op;
  logic       alu_step;
  logic       busy;
  logic       done;
  logic       done_id;
  logic       err;

  modport master (
    output req, op_sel0, op_sel1,
    input  gnt, load_alu, alu_op, alu_step, busy, done, done_id, err
  );

  modport slave (
    input  req, op_sel0, op_sel1,
    output gnt, load_alu, alu_op, alu_step, busy, done, done_id, err
  );
endinterface

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2 -- 2-way round-robin arbiter.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_req[1:0]    : request vector
//   i_advance     : the current grant is being taken; rotate priority
//   o_gnt[1:0]    : one-hot combinational grant (zero when no request)
// A lone request always wins; on contention the requester holding priority
// wins. After reset requester 0 holds priority.
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  logic       r_prio;  // index of the requester that wins a tie
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    case (i_req)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = r_prio ? 2'b10 : 2'b01;
      default: w_gnt = 2'b00;
    endcase
  end

  // Priority passes to the requester that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_prio <= 1'b0;
    else if (i_advance && (w_gnt != 2'b00))
      r_prio <= w_gnt[0];
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer -- arbitrates two requesters and sequences one ALU operation
// at a time through IDLE -> LOAD -> EXEC -> DONE (Moore, registered outputs).
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : alu_sequencer_if.slave (req/op_sel in; gnt, load_alu, alu_op,
//              alu_step, busy, done, done_id, err out)
// Parameters: MUL_CYCLES, DIV_CYCLES (1..15) -- EXEC length for MUL/DIV.
// Build option: define ALU_DIV_EN to sequence DIV; otherwise a captured DIV
// completes immediately with err=1 and never touches the ALU.
// ---------------------------------------------------------------------------
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input logic             clk,
  input logic             reset_n,
  alu_sequencer_if.slave  bus
);

  state_e     r_state;
  logic [3:0] r_cnt;
  logic       r_id;
  op_e        r_alu_op;
  logic [1:0] r_gnt;
  logic       r_load;
  logic       r_step;
  logic       r_done;
  logic       r_done_id;
  logic       r_err;

  logic       w_start;
  logic [1:0] w_gnt;
  logic       w_id;
  op_e        w_op;
  logic       w_unsup;

  function automatic logic [3:0] exec_len(input op_e op);
    case (op)
      OP_MUL:  return 4'(MUL_CYCLES);
      OP_DIV:  return 4'(DIV_CYCLES);
      default: return 4'd1;
    endcase
  endfunction

  assign w_start = (r_state == ST_IDLE) && (bus.req != 2'b00);

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_req     (bus.req),
    .i_advance (w_start),
    .o_gnt     (w_gnt)
  );

  assign w_id = w_gnt[1];
  assign w_op = w_id ? op_e'(bus.op_sel1) : op_e'(bus.op_sel0);

`ifdef ALU_DIV_EN
  assign w_unsup = 1'b0;
`else
  assign w_unsup = (w_op == OP_DIV);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_id      <= 1'b0;
      r_alu_op  <= OP_ADD;
      r_gnt     <= 2'b00;
      r_load    <= 1'b0;
      r_step    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // single-cycle pulses default low
      r_gnt     <= 2'b00;
      r_load    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_id     <= w_id;
            r_alu_op <= w_op;
            r_gnt    <= w_gnt;
            if (w_unsup) begin
              // rejected op: grant and completion share one cycle
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_done_id <= w_id;
              r_err     <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
              r_load  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          r_state <= ST_EXEC;
          r_cnt   <= exec_len(r_alu_op);
          r_step  <= 1'b1;
        end
        ST_EXEC: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state   <= ST_DONE;
            r_step    <= 1'b0;
            r_done    <= 1'b1;
            r_done_id <= r_id;
          end
        end
        ST_DONE: begin
          // always return to IDLE; no grant straight out of DONE
          r_state  <= ST_IDLE;
          r_alu_op <= OP_ADD;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.load_alu = r_load;
  assign bus.alu_op   = r_alu_op;
  assign bus.alu_step = r_step;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = r_done;
  assign bus.done_id  = r_done_id;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer -- directed and randomized bench for alu_sequencer.
// Expected behaviour comes from a transaction-level model: round-robin
// winner selection plus per-cycle expectations derived from the operation
// latency (ADD/SUB 3 cycles, MUL/DIV 2+N, rejected DIV 1 cycle).
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int MUL_N = 8;
  localparam int DIV_N = 8;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   prio;
  int   txn;

  alu_sequencer_if bus ();

  alu_sequencer #(
    .MUL_CYCLES (MUL_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".gnt"},     4'(bus.gnt),      4'd0);
    chk({tag, ".load"},    4'(bus.load_alu), 4'd0);
    chk({tag, ".alu_op"},  4'(bus.alu_op),   4'd0);
    chk({tag, ".step"},    4'(bus.alu_step), 4'd0);
    chk({tag, ".busy"},    4'(bus.busy),     4'd0);
    chk({tag, ".done"},    4'(bus.done),     4'd0);
    chk({tag, ".done_id"}, 4'(bus.done_id),  4'd0);
    chk({tag, ".err"},     4'(bus.err),      4'd0);
  endtask

  function automatic int exec_len(input logic [1:0] op);
    if (op == 2'b10) return MUL_N;
    if (op == 2'b11) return DIV_N;
    return 1;
  endfunction

  // One transaction: present rv at an idle cycle, then check every cycle
  // until the first idle cycle after completion.
  task automatic run_txn(input logic [1:0] rv, input logic [1:0] o0,
                         input logic [1:0] o1, input bit hold);
    int         w;
    int         len;
    bit         unsup;
    logic [1:0] op;
    string      t;
    w     = (rv == 2'b01) ? 0 : (rv == 2'b10) ? 1 : prio;
    prio  = 1 - w;
    op    = (w == 1) ? o1 : o0;
    unsup = 1'b0;
`ifndef ALU_DIV_EN
    unsup = (op == 2'b11);
`endif
    len = unsup ? 1 : 2 + exec_len(op);
    bus.req     = rv;
    bus.op_sel0 = o0;
    bus.op_sel1 = o1;
    tick();
    for (int k = 1; k <= len; k++) begin
      t = $sformatf("t%0d.c%0d", txn, k);
      chk({t, ".gnt"},    4'(bus.gnt),      (k == 1) ? ((w == 1) ? 4'd2 : 4'd1) : 4'd0);
      chk({t, ".load"},   4'(bus.load_alu), (k == 1 && !unsup) ? 4'd1 : 4'd0);
      chk({t, ".step"},   4'(bus.alu_step), (k >= 2 && k <= len - 1) ? 4'd1 : 4'd0);
      chk({t, ".done"},   4'(bus.done),     (k == len) ? 4'd1 : 4'd0);
      chk({t, ".alu_op"}, 4'(bus.alu_op),   4'(op));
      chk({t, ".busy"},   4'(bus.busy),     4'd1);
      if (k == len) begin
        chk({t, ".done_id"}, 4'(bus.done_id), 4'(w));
        chk({t, ".err"},     4'(bus.err),     unsup ? 4'd1 : 4'd0);
      end
      // requests and op changes while busy must have no effect
      if (!hold) bus.req = 2'($urandom_range(0, 3));
      bus.op_sel0 = 2'($urandom_range(0, 3));
      bus.op_sel1 = 2'($urandom_range(0, 3));
      tick();
    end
    chk_quiet($sformatf("t%0d.idle", txn));
    bus.req = hold ? rv : 2'b00;
    txn++;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    prio        = 0;
    txn         = 0;
    reset_n     = 1'b0;
    bus.req     = 2'b00;
    bus.op_sel0 = 2'b00;
    bus.op_sel1 = 2'b00;

    tick();
    tick();
    chk_quiet("reset");
    reset_n = 1'b1;
    tick();
    chk_quiet("post_reset");

    // lone ADD from requester 0
    run_txn(2'b01, 2'b00, 2'b11, 1'b0);
    // lone MUL from requester 1
    run_txn(2'b10, 2'b01, 2'b10, 1'b0);

    // fresh reset, then both requesting ADD continuously: 0,1,0,1
    reset_n = 1'b0;
    #1;
    chk_quiet("rst2");
    prio = 0;
    tick();
    reset_n = 1'b1;
    tick();
    run_txn(2'b11, 2'b00, 2'b00, 1'b1);
    run_txn(2'b11, 2'b00, 2'b00, 1'b1);
    run_txn(2'b11, 2'b00, 2'b00, 1'b1);
    run_txn(2'b11, 2'b00, 2'b00, 1'b0);

    // DIV from requester 0 (sequenced or rejected by build option)
    run_txn(2'b01, 2'b11, 2'b00, 1'b0);
    // SUB from requester 1
    run_txn(2'b10, 2'b00, 2'b01, 1'b0);

    // randomized traffic
    for (int i = 0; i < 16; i++) begin
      run_txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 1'b0);
    end

    // MUL aborted by reset in its 4th EXEC cycle
    bus.req     = 2'b01;
    bus.op_sel0 = 2'b10;
    tick();
    bus.req = 2'b00;
    for (int k = 0; k < 4; k++) tick();
    chk("abort.step_before", 4'(bus.alu_step), 4'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_quiet("abort.reset");
    prio = 0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("abort.nodone%0d", k), 4'(bus.done), 4'd0);
      chk($sformatf("abort.idle%0d", k),   4'(bus.busy), 4'd0);
      tick();
    end
    // pointer back at requester 0 after reset
    run_txn(2'b11, 2'b00, 2'b01, 1'b0);
    run_txn(2'b11, 2'b10, 2'b01, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
